// File: rtl/execute_unit_md.sv
// -----------------------------------------------------------------------------
// execute_unit_md
//
// Registered RISC-V execute stage with RV32M multiply/divide. The output
// registers form the EX/MEM boundary.
//   - ALU / branch / jump ops: accepted and completed in one cycle, so the unit
//     can take one op per cycle.
//   - MUL/MULH/MULHSU/MULHU: result ready MUL_LAT cycles after accept.
//   - DIV/DIVU/REM/REMU: restoring divider, one quotient bit per cycle, result
//     ready DATA_WIDTH+2 cycles after accept.
//
// Optional feature macro: EXEC_DIV_EARLY_OUT_EN
//   When defined, divide-by-zero and signed overflow (MIN / -1) skip the
//   iterative divider and complete with ALU latency. The result values are
//   the same either way.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready    op handshake from decode (accept = both high)
//   busy                   multi-cycle op in flight (= !in_ready)
//   flush                  kill in-flight op and any op offered this cycle
//   pc, PcOp               PC of op; target base select (0: pc, 1: rd1/JALR)
//   ALUctrl, ALUSrc        ALU operation, second-operand select
//   MdOp, MdFunct          RV32M op flag and funct3
//   ImmExt, rd1, rd2       immediate and register operands
//   Branch, Jump, branch_neg  branch/jump control
//   out_valid              one-cycle pulse: result registers updated
//   ALUResult, PCTarget, PCSrc  registered results
// -----------------------------------------------------------------------------
module execute_unit_md #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  PcOp,
    input  logic [2:0]            ALUctrl,
    input  logic                  ALUSrc,
    input  logic                  MdOp,
    input  logic [2:0]            MdFunct,
    input  logic [DATA_WIDTH-1:0] ImmExt,
    input  logic [DATA_WIDTH-1:0] rd1,
    input  logic [DATA_WIDTH-1:0] rd2,
    input  logic                  Branch,
    input  logic                  Jump,
    input  logic                  branch_neg,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic [DATA_WIDTH-1:0] PCTarget,
    output logic                  PCSrc,
    output logic                  busy
);

    localparam int W       = DATA_WIDTH;
    localparam int SHW     = $clog2(W);
    localparam int CNT_MAX = (W > MUL_LAT) ? W : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(W - 1);
    localparam logic [W-1:0]     MIN_VAL  = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DIV_FIX} state_t;

    // Result for the two divide corner cases (divide by zero, MIN / -1).
    function automatic logic [W-1:0] div_special(input logic is_rem,
                                                 input logic by_zero,
                                                 input logic [W-1:0] dividend);
        if (by_zero) div_special = is_rem ? dividend : {W{1'b1}};
        else         div_special = is_rem ? {W{1'b0}} : MIN_VAL;
    endfunction

    // Control / output state (reset)
    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   alu_result_q, alu_result_d;
    logic [W-1:0]   pc_target_q, pc_target_d;
    logic           pc_src_q, pc_src_d;

    // Datapath state (not reset; only read in the states that load it first)
    logic [W-1:0]   mul_res_q, mul_res_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W:0]     rem_q, rem_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [W-1:0]   dvd_q, dvd_d;
    logic           quo_neg_q, quo_neg_d;
    logic           rem_neg_q, rem_neg_d;
    logic           is_rem_q, is_rem_d;
    logic           div_zero_q, div_zero_d;
    logic           div_ovf_q, div_ovf_d;

    // ---------------------------------------------------------------- ALU path
    logic [W-1:0] op2, alu_res, tgt_sum, pc_tgt;
    logic         alu_cond, pc_src_alu;

    always_comb begin
        op2      = ALUSrc ? ImmExt : rd2;
        alu_res  = '0;
        alu_cond = 1'b0;
        case (ALUctrl)
            3'b000: begin
                alu_res  = rd1 + op2;
                alu_cond = (alu_res == '0);
            end
            3'b001: begin
                alu_res  = rd1 - op2;
                alu_cond = (alu_res == '0);
            end
            3'b010: alu_res = rd1 & op2;
            3'b011: alu_res = rd1 | op2;
            3'b100: alu_res = rd1 ^ op2;
            3'b101: begin
                alu_res  = {{(W-1){1'b0}}, ($signed(rd1) < $signed(op2))};
                alu_cond = alu_res[0];
            end
            3'b110: alu_res = rd1 << op2[SHW-1:0];
            3'b111: alu_res = rd1 >> op2[SHW-1:0];
        endcase
        tgt_sum    = (PcOp ? rd1 : pc) + ImmExt;
        // JALR clears bit 0 of the computed target
        pc_tgt     = PcOp ? {tgt_sum[W-1:1], 1'b0} : tgt_sum;
        pc_src_alu = (Branch && (alu_cond ^ branch_neg)) || Jump;
    end

    // ---------------------------------------------------------- multiply path
    // Sign-extend each operand to 2W bits per the funct3 signedness; the low
    // 2W bits of the product of the extended values are then exact.
    logic           mul_a_sgn, mul_b_sgn;
    logic [2*W-1:0] mul_a, mul_b, mul_prod;
    logic [W-1:0]   mul_sel;

    always_comb begin
        mul_a_sgn = (MdFunct == 3'b001) || (MdFunct == 3'b010);
        mul_b_sgn = (MdFunct == 3'b001);
        mul_a     = {{W{mul_a_sgn & rd1[W-1]}}, rd1};
        mul_b     = {{W{mul_b_sgn & rd2[W-1]}}, rd2};
        mul_prod  = mul_a * mul_b;
        mul_sel   = (MdFunct[1:0] == 2'b00) ? mul_prod[W-1:0] : mul_prod[2*W-1:W];
    end

    // ------------------------------------------------------------ divide path
    logic         div_sgn, a_neg, b_neg, div_zero, div_ovf, div_early;
    logic [W-1:0] a_mag, b_mag;
    logic [W:0]   rem_shift, rem_diff;
    logic [W-1:0] q_fix, r_fix, div_fix_res;

    always_comb begin
        div_sgn  = ~MdFunct[0];
        a_neg    = div_sgn & rd1[W-1];
        b_neg    = div_sgn & rd2[W-1];
        a_mag    = a_neg ? -rd1 : rd1;
        b_mag    = b_neg ? -rd2 : rd2;
        div_zero = (rd2 == '0);
        div_ovf  = div_sgn && (rd1 == MIN_VAL) && (rd2 == {W{1'b1}});
`ifdef EXEC_DIV_EARLY_OUT_EN
        div_early = div_zero || div_ovf;
`else
        div_early = 1'b0;
`endif
        // Partial remainder stays below the divisor, so bit W of the
        // trial difference is a valid borrow flag.
        rem_shift = {rem_q[W-1:0], quo_q[W-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};

        q_fix = quo_neg_q ? -quo_q : quo_q;
        r_fix = rem_neg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
        div_fix_res = (div_zero_q || div_ovf_q) ? div_special(is_rem_q, div_zero_q, dvd_q)
                                                : (is_rem_q ? r_fix : q_fix);
    end

    // -------------------------------------------------------- handshake decode
    logic accept_ok, alu_done, mul_now, div_now, mul_done, fix_done, md_done;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = ~in_ready;
    assign accept_ok = in_valid && in_ready && !flush;
    assign alu_done  = accept_ok && !MdOp;
    assign mul_now   = accept_ok && MdOp && !MdFunct[2] && (MUL_LAT == 1);
    assign div_now   = accept_ok && MdOp && MdFunct[2] && div_early;
    assign mul_done  = (state_q == S_MUL) && (cnt_q == MUL_LAST) && !flush;
    assign fix_done  = (state_q == S_DIV_FIX) && !flush;
    assign md_done   = mul_now || div_now || mul_done || fix_done;

    // ------------------------------------------------------- next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_ok && MdOp) begin
                        if (!MdFunct[2] && (MUL_LAT > 1)) begin
                            state_d = S_MUL;
                            cnt_d   = CNT_W'(1);
                        end else if (MdFunct[2] && !div_early) begin
                            state_d = S_DIV;
                            cnt_d   = '0;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == MUL_LAST) state_d = S_IDLE;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
                S_DIV: begin
                    if (cnt_q == DIV_LAST) state_d = S_DIV_FIX;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
                S_DIV_FIX: state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------- output logic
    always_comb begin
        out_valid_d  = alu_done || md_done;
        alu_result_d = alu_result_q;
        pc_target_d  = pc_target_q;
        pc_src_d     = pc_src_q;
        if (alu_done) begin
            alu_result_d = alu_res;
            pc_target_d  = pc_tgt;
            pc_src_d     = pc_src_alu;
        end else if (md_done) begin
            pc_src_d = 1'b0;
            if (mul_now)       alu_result_d = mul_sel;
            else if (div_now)  alu_result_d = div_special(MdFunct[1], div_zero, rd1);
            else if (mul_done) alu_result_d = mul_res_q;
            else               alu_result_d = div_fix_res;
        end
    end

    // ------------------------------------------------------- datapath update
    always_comb begin
        mul_res_d  = mul_res_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        dvd_d      = dvd_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        is_rem_d   = is_rem_q;
        div_zero_d = div_zero_q;
        div_ovf_d  = div_ovf_q;
        if (accept_ok && MdOp) begin
            mul_res_d  = mul_sel;
            quo_d      = a_mag;
            rem_d      = '0;
            dvs_d      = b_mag;
            dvd_d      = rd1;
            quo_neg_d  = a_neg ^ b_neg;
            rem_neg_d  = a_neg;
            is_rem_d   = MdFunct[1];
            div_zero_d = div_zero;
            div_ovf_d  = div_ovf;
        end else if (state_q == S_DIV) begin
            if (!rem_diff[W]) begin
                rem_d = rem_diff;
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = rem_shift;
                quo_d = {quo_q[W-2:0], 1'b0};
            end
        end
    end

    // --------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            alu_result_q <= '0;
            pc_target_q  <= '0;
            pc_src_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            alu_result_q <= alu_result_d;
            pc_target_q  <= pc_target_d;
            pc_src_q     <= pc_src_d;
        end
    end

    always_ff @(posedge clk) begin
        mul_res_q  <= mul_res_d;
        quo_q      <= quo_d;
        rem_q      <= rem_d;
        dvs_q      <= dvs_d;
        dvd_q      <= dvd_d;
        quo_neg_q  <= quo_neg_d;
        rem_neg_q  <= rem_neg_d;
        is_rem_q   <= is_rem_d;
        div_zero_q <= div_zero_d;
        div_ovf_q  <= div_ovf_d;
    end

    assign out_valid = out_valid_q;
    assign ALUResult = alu_result_q;
    assign PCTarget  = pc_target_q;
    assign PCSrc     = pc_src_q;

endmodule

// File: tb/tb_execute_unit_md.sv
module tb_execute_unit_md;

    localparam int W       = 32;
    localparam int ML      = 2;
    localparam int DIV_LAT = W + 2;
`ifdef EXEC_DIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, flush;
    logic [W-1:0] pc;
    logic         PcOp;
    logic [2:0]   ALUctrl;
    logic         ALUSrc, MdOp;
    logic [2:0]   MdFunct;
    logic [W-1:0] ImmExt, rd1, rd2;
    logic         Branch, Jump, branch_neg;
    logic         out_valid;
    logic [W-1:0] ALUResult, PCTarget;
    logic         PCSrc, busy;

    int checks   = 0;
    int failures = 0;

    execute_unit_md #(.DATA_WIDTH(W), .MUL_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .pc(pc), .PcOp(PcOp), .ALUctrl(ALUctrl), .ALUSrc(ALUSrc),
        .MdOp(MdOp), .MdFunct(MdFunct), .ImmExt(ImmExt), .rd1(rd1), .rd2(rd2),
        .Branch(Branch), .Jump(Jump), .branch_neg(branch_neg),
        .out_valid(out_valid), .ALUResult(ALUResult), .PCTarget(PCTarget),
        .PCSrc(PCSrc), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; flush = 0; pc = '0; PcOp = 0; ALUctrl = 3'b000; ALUSrc = 0;
        MdOp = 0; MdFunct = 3'b000; ImmExt = '0; rd1 = '0; rd2 = '0;
        Branch = 0; Jump = 0; branch_neg = 0;
    endtask

    task automatic alu_op(input logic [2:0] ctrl, input logic src, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] imm,
                          input logic [W-1:0] pcv, input logic br, input logic bneg,
                          input logic jmp, input logic pcop);
        in_valid = 1; MdOp = 0; ALUctrl = ctrl; ALUSrc = src; rd1 = a; rd2 = b;
        ImmExt = imm; pc = pcv; Branch = br; branch_neg = bneg; Jump = jmp; PcOp = pcop;
    endtask

    task automatic md_issue(input logic [2:0] funct, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1; MdOp = 1; MdFunct = funct; rd1 = a; rd2 = b;
        Branch = 0; Jump = 0; branch_neg = 0;
    endtask

    // Issue an RV32M op, offer a spurious ALU op while busy, and check the
    // completion lands exactly lat cycles after accept.
    task automatic md_run(input string tag, input logic [2:0] funct, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int lat, input logic [W-1:0] exp);
        md_issue(funct, a, b);
        step();
        idle_inputs();
        for (int i = 1; i < lat; i++) begin
            chk1({tag, "_nvalid"}, out_valid, 1'b0);
            if (i == 1) begin
                chk1({tag, "_busy_rdy"}, in_ready, 1'b0);
                alu_op(3'b000, 1'b1, 32'h55, 32'h0, 32'h11, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            step();
        end
        idle_inputs();
        chk1({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_res"}, ALUResult, exp);
        chk1({tag, "_pcsrc"}, PCSrc, 1'b0);
        chk1({tag, "_rdy"}, in_ready, 1'b1);
        step();
        chk1({tag, "_pulse"}, out_valid, 1'b0);
        chk({tag, "_hold"}, ALUResult, exp);
    endtask

    int seen;

    initial begin
        idle_inputs();
        rst_n = 0;
        #2;
        chk1("rst_valid", out_valid, 1'b0);
        chk("rst_res", ALUResult, 32'h0);
        chk("rst_tgt", PCTarget, 32'h0);
        chk1("rst_pcsrc", PCSrc, 1'b0);
        chk1("rst_rdy", in_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        step();
        step();
        rst_n = 1;
        step();

        // ADD with taken branch (result zero)
        alu_op(3'b000, 1'b1, 32'd5, 32'h0, 32'hFFFFFFFB, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        idle_inputs();
        chk1("add_valid", out_valid, 1'b1);
        chk("add_res", ALUResult, 32'h0);
        chk1("add_pcsrc", PCSrc, 1'b1);
        chk("add_tgt", PCTarget, 32'h0FB);
        step();
        chk1("add_pulse", out_valid, 1'b0);
        chk("add_hold", ALUResult, 32'h0);

        // JALR: target bit 0 cleared
        alu_op(3'b000, 1'b1, 32'h2001, 32'h0, 32'h4, 32'h500, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk("jalr_tgt", PCTarget, 32'h2004);
        chk1("jalr_pcsrc", PCSrc, 1'b1);
        chk("jalr_res", ALUResult, 32'h2005);

        // Back-to-back ALU ops, one completion per cycle
        alu_op(3'b001, 1'b0, 32'd10, 32'd3, 32'h10, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk1("sub_valid", out_valid, 1'b1);
        chk("sub_res", ALUResult, 32'd7);
        chk1("sub_neg_pcsrc", PCSrc, 1'b1);
        chk("sub_tgt", PCTarget, 32'h210);
        alu_op(3'b100, 1'b1, 32'hF0, 32'h0, 32'hFF, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk1("xor_valid", out_valid, 1'b1);
        chk("xor_res", ALUResult, 32'h0F);
        chk1("xor_pcsrc", PCSrc, 1'b0);
        chk("xor_tgt", PCTarget, 32'h3FF);
        alu_op(3'b110, 1'b0, 32'd1, 32'd33, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk1("sll_valid", out_valid, 1'b1);
        chk("sll_res", ALUResult, 32'd2);
        alu_op(3'b111, 1'b0, 32'h80000000, 32'd4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("srl_res", ALUResult, 32'h08000000);
        alu_op(3'b010, 1'b0, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("and_res", ALUResult, 32'hF000);
        alu_op(3'b101, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        idle_inputs();
        chk1("slt_valid", out_valid, 1'b1);
        chk("slt_res", ALUResult, 32'd1);
        chk1("slt_pcsrc", PCSrc, 1'b1);
        step();
        chk1("b2b_end", out_valid, 1'b0);

        // Multiply
        md_run("mulh",   3'b001, 32'h80000000, 32'd2, ML, 32'hFFFFFFFF);
        md_run("mulhu",  3'b011, 32'h80000000, 32'd2, ML, 32'h00000001);
        md_run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, ML, 32'hFFFFFFFF);
        md_run("mul",    3'b000, 32'd7, 32'hFFFFFFFD, ML, 32'hFFFFFFEB);

        // Divide
        md_run("div",     3'b100, 32'hFFFFFFF9, 32'd2, DIV_LAT, 32'hFFFFFFFD);
        md_run("rem",     3'b110, 32'hFFFFFFF9, 32'd2, DIV_LAT, 32'hFFFFFFFF);
        md_run("divu",    3'b101, 32'd100, 32'd7, DIV_LAT, 32'd14);
        md_run("remu",    3'b111, 32'd100, 32'd7, DIV_LAT, 32'd2);
        md_run("divu_z",  3'b101, 32'h10, 32'h0, SPEC_LAT, 32'hFFFFFFFF);
        md_run("remu_z",  3'b111, 32'h10, 32'h0, SPEC_LAT, 32'h10);
        md_run("div_z",   3'b100, 32'hFFFFFFF8, 32'h0, SPEC_LAT, 32'hFFFFFFFF);
        md_run("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, SPEC_LAT, 32'h0);
        md_run("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, SPEC_LAT, 32'h80000000);

        // Flush mid-divide
        md_issue(3'b100, 32'hFFFFFFF9, 32'd2);
        step();
        idle_inputs();
        repeat (9) step();
        flush = 1;
        step();
        flush = 0;
        chk1("flush_nvalid", out_valid, 1'b0);
        chk1("flush_rdy", in_ready, 1'b1);
        seen = 0;
        repeat (40) begin
            step();
            if (out_valid) seen++;
        end
        chk("flush_no_pulse", 32'(seen), 32'h0);
        alu_op(3'b000, 1'b0, 32'd2, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle_inputs();
        chk1("post_flush_valid", out_valid, 1'b1);
        chk("post_flush_res", ALUResult, 32'd5);

        // Flush together with an accept kills that op
        alu_op(3'b000, 1'b0, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        flush = 1;
        step();
        idle_inputs();
        chk1("flush_acc_nvalid", out_valid, 1'b0);
        chk("flush_acc_hold", ALUResult, 32'd5);

        // Reset in the middle of a divide
        md_issue(3'b100, 32'd100, 32'd7);
        step();
        idle_inputs();
        repeat (5) step();
        chk1("mid_div_busy", busy, 1'b1);
        rst_n = 0;
        #1;
        chk1("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_res", ALUResult, 32'h0);
        chk1("rst_mid_rdy", in_ready, 1'b1);
        chk1("rst_mid_busy", busy, 1'b0);
        step();
        rst_n = 1;
        step();
        alu_op(3'b000, 1'b1, 32'd4, 32'h0, 32'd4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle_inputs();
        chk1("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_res", ALUResult, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
